fifo_stream_reader: RTL
=======================

// Module: fifo_stream_reader
// PURPOSE
//  Drains a fixed-length burst from a synchronous FIFO read port and re-presents it as a
//  valid/ready stream, e.g. FIFO -> systolic-array row feeder. Hides the FIFO's 1-cycle
//  registered read latency behind a 2-entry output buffer; sustains 1 word/cycle when the
//  FIFO stays non-empty and the sink stays ready. Never reads an empty FIFO.
// PARAMETERS
//  DATA_WIDTH  8   word width; matches the FIFO DATA_WIDTH
//  LEN_WIDTH   16  width of burst length; max burst = 2**LEN_WIDTH-1 words
// PORTS
//  clk         in   1           clock; all logic on posedge
//  rst         in   1           reset, synchronous, active-high
//  start       in   1           1-cycle pulse: begin burst of len words (ignored while busy)
//  len         in   LEN_WIDTH   burst length, sampled with start
//  busy        out  1           high from cycle after accepted start until done pulse
//  done        out  1           1-cycle pulse after last word accepted (or after len==0 start)
//  fifo_re     out  1           FIFO read enable (combinational)
//  fifo_empty  in   1           FIFO empty flag
//  fifo_rdata  in   DATA_WIDTH  FIFO read data, valid the cycle after a granted read
//  out_valid   out  1           stream valid (registered, = buffer occupancy > 0)
//  out_ready   in   1           stream ready from sink
//  out_data    out  DATA_WIDTH  buffer head word
//  out_last    out  1           high with the final word of the burst
// BEHAVIOUR
//  - Reset: state IDLE; busy, done, out_valid, out_last, fifo_re = 0; buffer occupancy 0,
//    counters 0, in-flight flag 0. Reset mid-burst discards buffer and any in-flight read
//    (that FIFO word is lost; the FIFO itself is reset by the same rst).
//  - FSM IDLE -> RUN on start && len!=0: latch issue_left=len, emit_left=len.
//    start && len==0: stay IDLE, done=1 next cycle. start in RUN is ignored.
//    RUN -> IDLE on the handshake (out_valid && out_ready) of the last word; done=1 next cycle.
//  - pop = out_valid && out_ready. fifo_re = RUN && !fifo_empty && issue_left!=0 &&
//    (occ + inflight - pop) < 2. Each fifo_re decrements issue_left, sets inflight next cycle.
//  - inflight=1: fifo_rdata is written to buffer tail that cycle (occ+1); a same-cycle pop
//    leaves occ unchanged. Buffer is FIFO-ordered; out_data = head, stable while !out_ready.
//  - Overflow impossible by credit rule; occ never exceeds 2. out_valid never drops without pop.
//  - out_last = out_valid && emit_left==1. Each pop decrements emit_left.
//  - Latency: start at edge 0 -> fifo_re in cycle 1 (FIFO non-empty) -> out_valid cycle 3.
//  - Throughput: 1 word/cycle steady state with out_ready=1 and FIFO non-empty.
//  - FIFO empty mid-burst: fifo_re held low, stream bubbles, resumes when data arrives; no
//    timeout. out_ready low: at most 2 words buffered, then fifo_re held low.
//  - Arithmetic: counters LEN_WIDTH bits, never decremented below 0; occ 2 bits.
// TESTING
//  1 FIFO preloaded 0x10..0x13, start len=4, out_ready=1 -> out_data 10,11,12,13 on consecutive
//    cycles starting cycle 3, out_last with 0x13, done 1 cycle after, busy low after.
//  2 len=0 start -> fifo_re never asserted, done pulses next cycle, busy stays 0.
//  3 FIFO of 8 words, len=8, out_ready toggles 1,0,0,1,... -> order preserved, out_data stable
//    while stalled, occ<=2, exactly 8 fifo_re, FIFO ends empty.
//  4 FIFO empty at start, push 1 word every 3 cycles, len=3 -> fifo_re only when !fifo_empty,
//    3 words out in order, no spurious out_valid.
//  5 rst asserted mid-burst with occ=2 -> next cycle all outputs 0, state IDLE; new start
//    len=2 after refill works normally.
//  6 start pulsed again while busy -> ignored; burst length unchanged, single done.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// Drains a fixed-length burst from a registered-read FIFO port and re-presents it
// as a valid/ready stream through a 2-entry skid buffer.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  output logic                  fifo_re,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  logic                  state_q, state_d;
  logic [LEN_WIDTH-1:0]  issue_left_q, issue_left_d;
  logic [LEN_WIDTH-1:0]  emit_left_q, emit_left_d;
  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
  logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
  logic                  pop;
  logic [2:0]            credit;

  assign busy      = (state_q == ST_RUN);
  assign done      = done_q;
  assign out_valid = (occ_q != 2'd0);
  assign out_data  = buf0_q;
  assign out_last  = out_valid && (emit_left_q == LEN_WIDTH'(1));

  always_comb begin
    pop    = (occ_q != 2'd0) && out_ready;
    // Words already buffered plus the one in flight, less the one leaving now,
    // must leave room for the word a new read would deliver.
    credit = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    fifo_re = (state_q == ST_RUN) && !fifo_empty && (issue_left_q != '0) && (credit < 3'd2);

    state_d      = state_q;
    issue_left_d = issue_left_q;
    emit_left_d  = emit_left_q;
    occ_d        = occ_q;
    inflight_d   = fifo_re;
    done_d       = 1'b0;
    buf0_d       = buf0_q;
    buf1_d       = buf1_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len != '0) begin
            state_d      = ST_RUN;
            issue_left_d = len;
            emit_left_d  = len;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      default: begin
        if (pop && (emit_left_q == LEN_WIDTH'(1))) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
    endcase

    if (fifo_re && (issue_left_q != '0)) begin
      issue_left_d = issue_left_q - LEN_WIDTH'(1);
    end
    if (pop && (emit_left_q != '0)) begin
      emit_left_d = emit_left_q - LEN_WIDTH'(1);
    end

    // Head always lives in buf0; a pop shifts buf1 forward before the new tail lands.
    if (inflight_q && pop) begin
      if (occ_q == 2'd1) begin
        buf0_d = fifo_rdata;
      end else begin
        buf0_d = buf1_q;
        buf1_d = fifo_rdata;
      end
    end else if (inflight_q) begin
      if (occ_q == 2'd0) begin
        buf0_d = fifo_rdata;
      end else begin
        buf1_d = fifo_rdata;
      end
      occ_d = occ_q + 2'd1;
    end else if (pop) begin
      buf0_d = buf1_q;
      occ_d  = occ_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      issue_left_q <= '0;
      emit_left_q  <= '0;
      occ_q        <= 2'd0;
      inflight_q   <= 1'b0;
      done_q       <= 1'b0;
      buf0_q       <= '0;
      buf1_q       <= '0;
    end else begin
      state_q      <= state_d;
      issue_left_q <= issue_left_d;
      emit_left_q  <= emit_left_d;
      occ_q        <= occ_d;
      inflight_q   <= inflight_d;
      done_q       <= done_d;
      buf0_q       <= buf0_d;
      buf1_q       <= buf1_d;
    end
  end

endmodule
